// File: rtl/voice_scheduler_pkg.sv
// rtl/voice_scheduler_pkg.sv - shared types and default widths for the voice scheduler
package voice_scheduler_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int PHASE_W_DEF    = 16;
  localparam int SAMPLE_W_DEF   = 8;
  localparam int SAMPLE_DIV_DEF = 256;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} sched_state_t;

  typedef logic [$clog2(NUM_VOICES_DEF)-1:0] voice_idx_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// rtl/voice_scheduler_if.sv - config, oscillator and mix signals of the voice scheduler
interface voice_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_W   = 8
);
  localparam int VIDX_W = $clog2(NUM_VOICES);

  logic                cfg_we;
  logic [VIDX_W-1:0]   cfg_voice;
  logic [PHASE_W-1:0]  cfg_inc;
  logic                cfg_active;
  logic [PHASE_W-1:0]  osc_phase;
  logic                osc_req;
  logic [SAMPLE_W-1:0] osc_sample;
  logic [SAMPLE_W-1:0] mix_out;
  logic                mix_valid;

  // master: note decoder plus oscillator/output stage; slave: the scheduler
  modport master (
    output cfg_we, cfg_voice, cfg_inc, cfg_active, osc_sample,
    input  osc_phase, osc_req, mix_out, mix_valid
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_inc, cfg_active, osc_sample,
    output osc_phase, osc_req, mix_out, mix_valid
  );

endinterface

// File: rtl/voice_scheduler_tick_gen.sv
// rtl/voice_scheduler_tick_gen.sv - audio sample divider producing one tick per sample period
module voice_scheduler_tick_gen #(
  parameter int SAMPLE_DIV = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // frozen divider must not keep re-firing a tick while parked on LAST
  assign tick = en && (count == LAST);

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - sweeps all voices through one shared oscillator once per sample
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  voice_scheduler_if.slave   bus,
  output logic               overrun
);
  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + VIDX_W;

  typedef logic [VIDX_W-1:0] vidx_t;
  localparam vidx_t LAST_V = vidx_t'(NUM_VOICES - 1);

  logic [PHASE_W-1:0]    phase [NUM_VOICES];
  logic [PHASE_W-1:0]    inc   [NUM_VOICES];
  logic [NUM_VOICES-1:0] active;

  sched_state_t     state;
  vidx_t            v;
  vidx_t            v_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             tick;

  voice_scheduler_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    v_next   = v + vidx_t'(1);
    acc_next = acc;
    if (active[v]) begin
      acc_next = acc + ACC_W'(bus.osc_sample);
    end
  end

  // a write landing on a voice's CAPTURE edge only takes effect next sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        inc[i] <= '0;
      end
      active <= '0;
    end else if (bus.cfg_we) begin
      inc[bus.cfg_voice]    <= bus.cfg_inc;
      active[bus.cfg_voice] <= bus.cfg_active;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      v             <= '0;
      acc           <= '0;
      bus.osc_phase <= '0;
      bus.osc_req   <= 1'b0;
      bus.mix_out   <= '0;
      bus.mix_valid <= 1'b0;
      overrun       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
      end
    end else begin
      bus.osc_req   <= 1'b0;
      bus.mix_valid <= 1'b0;
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            acc           <= '0;
            v             <= '0;
            bus.osc_phase <= phase[0];
            bus.osc_req   <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          acc      <= acc_next;
          phase[v] <= active[v] ? phase[v] + inc[v] : '0;
          if (v == LAST_V) begin
            bus.mix_out   <= acc_next[ACC_W-1:VIDX_W];
            bus.mix_valid <= 1'b1;
            state         <= DONE;
          end else begin
            v             <= v_next;
            bus.osc_phase <= phase[v_next];
            bus.osc_req   <= 1'b1;
            state         <= ISSUE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - scoreboard bench for voice_scheduler with an oscillator model
module tb_voice_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic en_ovr = 1'b1;
  logic overrun;
  logic overrun_ovr;

  always #5 clk = ~clk;

  voice_scheduler_if #(.NUM_VOICES(4), .PHASE_W(16), .SAMPLE_W(8)) bus ();
  voice_scheduler_if #(.NUM_VOICES(4), .PHASE_W(16), .SAMPLE_W(8)) bus_ovr ();

  voice_scheduler #(.NUM_VOICES(4), .PHASE_W(16), .SAMPLE_W(8), .SAMPLE_DIV(256)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus.slave),
    .overrun (overrun)
  );

  // sample period deliberately shorter than a sweep
  voice_scheduler #(.NUM_VOICES(4), .PHASE_W(16), .SAMPLE_W(8), .SAMPLE_DIV(8)) dut_ovr (
    .clk     (clk),
    .rst     (rst),
    .en      (en_ovr),
    .bus     (bus_ovr.slave),
    .overrun (overrun_ovr)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int osc_mode = 0;
  int m_phase [4];
  int m_inc [4];
  bit m_act [4];
  int phase_q [$];
  int mix_q [$];

  function automatic int samp(input int ph);
    case (osc_mode)
      0:       return (ph >> 8) & 255;
      1:       return 255;
      default: return ph & 255;
    endcase
  endfunction

  task automatic push_sweep();
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      phase_q.push_back(m_phase[i]);
      if (m_act[i]) sum += samp(m_phase[i]);
      m_phase[i] = m_act[i] ? ((m_phase[i] + m_inc[i]) & 16'hFFFF) : 0;
    end
    mix_q.push_back(sum >> 2);
  endtask

  // oscillator model: registered, result valid only in the cycle after osc_req
  always @(posedge clk) begin
    if (bus.osc_req) begin
      case (osc_mode)
        0:       bus.osc_sample <= bus.osc_phase[15:8];
        1:       bus.osc_sample <= 8'hFF;
        default: bus.osc_sample <= bus.osc_phase[7:0];
      endcase
    end else begin
      bus.osc_sample <= 8'h00;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0;
  int req_cnt = 0;
  int first_req = 0;
  int last_valid = 0;
  bit have_last = 1'b0;
  bit period_chk = 1'b0;
  bit ignore_osc = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      req_cnt = 0;
      have_last = 1'b0;
    end else begin
      if (bus.osc_req && !ignore_osc) begin
        if (phase_q.size() == 0) check_val("osc_req_unexpected", 1, 0);
        else check_val("osc_phase", bus.osc_phase, phase_q.pop_front());
        if (req_cnt == 0) first_req = cyc;
        req_cnt++;
      end
      if (bus.mix_valid) begin
        if (mix_q.size() == 0) check_val("mix_valid_unexpected", 1, 0);
        else check_val("mix_out", bus.mix_out, mix_q.pop_front());
        check_val("req_to_valid_latency", cyc - first_req, 8);
        if (period_chk && have_last) check_val("mix_period", cyc - last_valid, 256);
        last_valid = cyc;
        have_last = 1'b1;
        req_cnt = 0;
        n_valid++;
      end
    end
  end

  task automatic wait_valid(input int target);
    int k = 0;
    while (n_valid < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (n_valid < target) check_val("mix_timeout", n_valid, target);
  endtask

  task automatic wait_req();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.osc_req && k < 1000);
    if (!bus.osc_req) check_val("osc_req_timeout", 0, 1);
  endtask

  task automatic cfg_write(input int vi, input int inc_val, input bit act);
    @(posedge clk);
    #1;
    bus.cfg_we     = 1'b1;
    bus.cfg_voice  = 2'(vi);
    bus.cfg_inc    = 16'(inc_val);
    bus.cfg_active = act;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    m_inc[vi] = inc_val;
    m_act[vi] = act;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_mix_out"}, bus.mix_out, 0);
    check_val({tag, "_mix_valid"}, bus.mix_valid, 0);
    check_val({tag, "_osc_req"}, bus.osc_req, 0);
    check_val({tag, "_osc_phase"}, bus.osc_phase, 0);
    check_val({tag, "_overrun"}, overrun, 0);
    check_val({tag, "_overrun_ovr"}, overrun_ovr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    bus.cfg_we = 1'b0;
    bus.cfg_voice = '0;
    bus.cfg_inc = '0;
    bus.cfg_active = 1'b0;
    bus_ovr.cfg_we = 1'b0;
    bus_ovr.cfg_voice = '0;
    bus_ovr.cfg_inc = '0;
    bus_ovr.cfg_active = 1'b0;
    bus_ovr.osc_sample = '0;
    for (int i = 0; i < 4; i++) begin
      m_phase[i] = 0;
      m_inc[i] = 0;
      m_act[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;

    // single voice, phase[15:8] oscillator
    cfg_write(0, 16'h0100, 1'b1);
    period_chk = 1'b1;
    base = n_valid;
    for (int s = 0; s < 6; s++) push_sweep();
    wait_valid(base + 6);
    period_chk = 1'b0;

    // wrap: zero voice0 phase with one inactive sweep, then step by 0xFF00
    cfg_write(0, 16'hFF00, 1'b0);
    base = n_valid;
    push_sweep();
    wait_valid(base + 1);
    cfg_write(0, 16'hFF00, 1'b1);
    base = n_valid;
    for (int s = 0; s < 4; s++) push_sweep();
    wait_valid(base + 4);

    // full mix with a constant full-scale oscillator
    osc_mode = 1;
    cfg_write(1, 16'h1234, 1'b1);
    cfg_write(2, 16'h0777, 1'b1);
    cfg_write(3, 16'h0001, 1'b1);
    base = n_valid;
    push_sweep();
    push_sweep();
    wait_valid(base + 2);
    check_val("overrun_ovr_set", overrun_ovr, 1);

    // config race on voice 2's CAPTURE cycle
    osc_mode = 2;
    cfg_write(0, 0, 1'b0);
    cfg_write(1, 0, 1'b0);
    cfg_write(3, 0, 1'b0);
    cfg_write(2, 16'h0010, 1'b1);
    base = n_valid;
    push_sweep();
    m_inc[2] = 16'h0020;
    push_sweep();
    push_sweep();
    seen = 0;
    for (int k = 0; k < 1000 && seen < 3; k++) begin
      @(negedge clk);
      if (bus.osc_req) seen++;
    end
    check_val("race_req_seen", seen, 3);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b1;
    bus.cfg_voice = 2'd2;
    bus.cfg_inc = 16'h0020;
    bus.cfg_active = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    wait_valid(base + 3);

    // en dropped mid-sweep: this sweep finishes, then nothing
    base = n_valid;
    push_sweep();
    wait_req();
    en = 1'b0;
    wait_valid(base + 1);
    repeat (600) @(negedge clk);
    check_val("en_off_no_valid", n_valid, base + 1);
    en = 1'b1;
    check_val("overrun_ovr_sticky", overrun_ovr, 1);
    check_val("overrun_main", overrun, 0);

    // asynchronous reset in the middle of a sweep
    ignore_osc = 1'b1;
    wait_req();
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midsweep_rst");
    for (int i = 0; i < 4; i++) begin
      m_phase[i] = 0;
      m_inc[i] = 0;
      m_act[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    ignore_osc = 1'b0;
    base = n_valid;
    repeat (200) @(negedge clk);
    check_val("post_rst_no_valid", n_valid, base);

    osc_mode = 0;
    cfg_write(1, 16'h0800, 1'b1);
    base = n_valid;
    for (int s = 0; s < 3; s++) push_sweep();
    wait_valid(base + 3);

    check_val("mix_q_empty", mix_q.size(), 0);
    check_val("phase_q_empty", phase_q.size(), 0);
    check_val("overrun_final", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
